// File: rtl/hazard_scoreboard_pkg.sv
// mips_hazard_pkg: opcode/funct codes, Tuse/Tnew constants, forwarding
// select encodings and the instruction-class enum shared by the hazard
// scoreboard and its decoder. MULT/DIV related classes are only produced
// when MDU_HAZARD_EN is defined.
package mips_hazard_pkg;

    // Primary opcodes
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0a;
    localparam logic [5:0] OP_SLTIU   = 6'h0b;
    localparam logic [5:0] OP_ANDI    = 6'h0c;
    localparam logic [5:0] OP_ORI     = 6'h0d;
    localparam logic [5:0] OP_XORI    = 6'h0e;
    localparam logic [5:0] OP_LUI     = 6'h0f;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SH      = 6'h29;
    localparam logic [5:0] OP_SW      = 6'h2b;

    // SPECIAL funct codes
    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1a;
    localparam logic [5:0] FN_DIVU  = 6'h1b;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2a;
    localparam logic [5:0] FN_SLTU  = 6'h2b;

    // Tuse: cycles after D before the operand is consumed.
    // TUSE_NONE marks an unused source; it exceeds every Tnew so never stalls.
    localparam logic [1:0] TUSE_0    = 2'd0;
    localparam logic [1:0] TUSE_1    = 2'd1;
    localparam logic [1:0] TUSE_2    = 2'd2;
    localparam logic [1:0] TUSE_NONE = 2'd3;

    // Tnew at E entry: cycles until the result exists in the pipe.
    localparam logic [1:0] TNEW_0 = 2'd0;
    localparam logic [1:0] TNEW_1 = 2'd1;
    localparam logic [1:0] TNEW_2 = 2'd2;

    // Bypass select encodings
    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_W  = 2'd1;
    localparam logic [1:0] FWD_M  = 2'd2;
    localparam logic [1:0] FWD_E  = 2'd3;

    typedef enum logic [3:0] {
        CLS_NOP,
        CLS_CAL_R,
        CLS_CAL_I,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_J,
        CLS_JAL,
        CLS_JR,
        CLS_JALR,
        CLS_MULT,
        CLS_DIV,
        CLS_MF,
        CLS_MT
    } instr_class_t;

endpackage

// File: rtl/hazard_scoreboard_decode.sv
// hazard_decode: combinational instruction -> {rs, rt, dst, tuse_rs,
// tuse_rt, tnew, class}. Unused source fields are reported as register 0
// so they can never match a producer. MULT/DIV/MFHI/MFLO/MTHI/MTLO are
// decoded only when MDU_HAZARD_EN is defined; otherwise they act as nop.
module hazard_decode
    import mips_hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int TNEW_W = 2
) (
    input  logic [31:0]       i_instr,
    output logic [REG_AW-1:0] o_rs,
    output logic [REG_AW-1:0] o_rt,
    output logic [REG_AW-1:0] o_dst,
    output logic [TNEW_W-1:0] o_tuse_rs,
    output logic [TNEW_W-1:0] o_tuse_rt,
    output logic [TNEW_W-1:0] o_tnew,
    output instr_class_t      o_cls
);

    localparam logic [TNEW_W-1:0] L_U0   = TNEW_W'(TUSE_0);
    localparam logic [TNEW_W-1:0] L_U1   = TNEW_W'(TUSE_1);
    localparam logic [TNEW_W-1:0] L_U2   = TNEW_W'(TUSE_2);
    localparam logic [TNEW_W-1:0] L_NONE = TNEW_W'(TUSE_NONE);
    localparam logic [TNEW_W-1:0] L_N0   = TNEW_W'(TNEW_0);
    localparam logic [TNEW_W-1:0] L_N1   = TNEW_W'(TNEW_1);
    localparam logic [TNEW_W-1:0] L_N2   = TNEW_W'(TNEW_2);

    logic [5:0]        w_op;
    logic [5:0]        w_fn;
    logic [REG_AW-1:0] w_rs_f;
    logic [REG_AW-1:0] w_rt_f;
    logic [REG_AW-1:0] w_rd_f;
    logic              w_unused_shamt;

    assign w_op           = i_instr[31:26];
    assign w_fn           = i_instr[5:0];
    assign w_rs_f         = REG_AW'(i_instr[25:21]);
    assign w_rt_f         = REG_AW'(i_instr[20:16]);
    assign w_rd_f         = REG_AW'(i_instr[15:11]);
    assign w_unused_shamt = ^i_instr[10:6];

    // Classify the instruction and assign its operand timing and destination
    always_comb begin
        o_cls     = CLS_NOP;
        o_dst     = '0;
        o_tnew    = L_N0;
        o_tuse_rs = L_NONE;
        o_tuse_rt = L_NONE;
        case (w_op)
            OP_SPECIAL: begin
                case (w_fn)
                    FN_JR: begin
                        o_cls     = CLS_JR;
                        o_tuse_rs = L_U0;
                    end
                    FN_JALR: begin
                        o_cls     = CLS_JALR;
                        o_tuse_rs = L_U0;
                        o_dst     = w_rd_f;
                        o_tnew    = L_N0;
                    end
                    FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
                    FN_XOR, FN_NOR, FN_SLT, FN_SLTU: begin
                        o_cls     = CLS_CAL_R;
                        o_tuse_rs = L_U1;
                        o_tuse_rt = L_U1;
                        o_dst     = w_rd_f;
                        o_tnew    = L_N1;
                    end
                    FN_SLL, FN_SRL, FN_SRA: begin
                        o_cls     = CLS_CAL_R;
                        o_tuse_rt = L_U1;
                        o_dst     = w_rd_f;
                        o_tnew    = L_N1;
                    end
`ifdef MDU_HAZARD_EN
                    FN_MULT, FN_MULTU: begin
                        o_cls     = CLS_MULT;
                        o_tuse_rs = L_U1;
                        o_tuse_rt = L_U1;
                    end
                    FN_DIV, FN_DIVU: begin
                        o_cls     = CLS_DIV;
                        o_tuse_rs = L_U1;
                        o_tuse_rt = L_U1;
                    end
                    FN_MFHI, FN_MFLO: begin
                        o_cls  = CLS_MF;
                        o_dst  = w_rd_f;
                        o_tnew = L_N1;
                    end
                    FN_MTHI, FN_MTLO: begin
                        o_cls     = CLS_MT;
                        o_tuse_rs = L_U1;
                    end
`endif
                    default: ;
                endcase
            end
            OP_J: o_cls = CLS_J;
            OP_JAL: begin
                o_cls  = CLS_JAL;
                o_dst  = REG_AW'(31);
                o_tnew = L_N0;
            end
            OP_BEQ, OP_BNE: begin
                o_cls     = CLS_BRANCH;
                o_tuse_rs = L_U0;
                o_tuse_rt = L_U0;
            end
            OP_BLEZ, OP_BGTZ: begin
                o_cls     = CLS_BRANCH;
                o_tuse_rs = L_U0;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI,
            OP_XORI, OP_LUI: begin
                o_cls     = CLS_CAL_I;
                o_tuse_rs = L_U1;
                o_dst     = w_rt_f;
                o_tnew    = L_N1;
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                o_cls     = CLS_LOAD;
                o_tuse_rs = L_U1;
                o_dst     = w_rt_f;
                o_tnew    = L_N2;
            end
            OP_SB, OP_SH, OP_SW: begin
                o_cls     = CLS_STORE;
                o_tuse_rs = L_U1;
                o_tuse_rt = L_U2;
            end
            default: ;
        endcase
    end

    // Unused sources read as $0 so they never hit a comparator
    assign o_rs = (o_tuse_rs != L_NONE) ? w_rs_f : '0;
    assign o_rt = (o_tuse_rt != L_NONE) ? w_rt_f : '0;

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: stall/forward controller for the 5-stage MIPS pipe.
// Keeps its own E/M/W shadow of {rs, rt, dst, tnew, class}, derives the
// stall and every bypass select combinationally from that shadow and the
// D-stage instruction. With MDU_HAZARD_EN defined a MULT/DIV busy counter
// adds HI/LO stalls; without it md_start/md_busy stay low.
module hazard_scoreboard
    import mips_hazard_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter int TNEW_W      = 2,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_d,
    output logic        stall,
    output logic [1:0]  fwd_rs_d,
    output logic [1:0]  fwd_rt_d,
    output logic [1:0]  fwd_rs_e,
    output logic [1:0]  fwd_rt_e,
    output logic        fwd_rt_m,
    output logic        md_start,
    output logic        md_busy
);

    // D-stage decode
    logic [REG_AW-1:0] w_d_rs, w_d_rt, w_d_dst;
    logic [TNEW_W-1:0] w_d_tuse_rs, w_d_tuse_rt, w_d_tnew;
    instr_class_t      w_d_cls;

    hazard_decode #(
        .REG_AW (REG_AW),
        .TNEW_W (TNEW_W)
    ) u_decode (
        .i_instr   (instr_d),
        .o_rs      (w_d_rs),
        .o_rt      (w_d_rt),
        .o_dst     (w_d_dst),
        .o_tuse_rs (w_d_tuse_rs),
        .o_tuse_rt (w_d_tuse_rt),
        .o_tnew    (w_d_tnew),
        .o_cls     (w_d_cls)
    );

    // Shadow pipeline (only the fields each stage's comparators need)
    logic [REG_AW-1:0] r_e_rs, r_e_rt, r_e_dst;
    logic [TNEW_W-1:0] r_e_tnew;
    instr_class_t      r_e_cls;
    logic [REG_AW-1:0] r_m_rt, r_m_dst;
    logic [TNEW_W-1:0] r_m_tnew;
    logic              r_m_rt_fwd_done;
    logic [REG_AW-1:0] r_w_dst;
    logic [TNEW_W-1:0] r_w_tnew;

    // Per-source comparator lanes: index 0 = rs, 1 = rt
    logic [REG_AW-1:0] w_d_src  [2];
    logic [TNEW_W-1:0] w_d_tuse [2];
    logic [REG_AW-1:0] w_e_src  [2];
    logic              w_src_stall [2];
    logic [1:0]        w_fwd_d  [2];
    logic [1:0]        w_fwd_e  [2];
    logic              w_md_stall;

    assign w_d_src[0]  = w_d_rs;
    assign w_d_src[1]  = w_d_rt;
    assign w_d_tuse[0] = w_d_tuse_rs;
    assign w_d_tuse[1] = w_d_tuse_rt;
    assign w_e_src[0]  = r_e_rs;
    assign w_e_src[1]  = r_e_rt;

    function automatic logic [TNEW_W-1:0] f_tnew_dec(input logic [TNEW_W-1:0] t);
        return (t == '0) ? '0 : t - TNEW_W'(1);
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            // A producer still needing more cycles than the consumer can wait stalls D
            assign w_src_stall[gi] = (w_d_src[gi] != '0) &&
                ((r_e_dst == w_d_src[gi] && r_e_tnew > w_d_tuse[gi]) ||
                 (r_m_dst == w_d_src[gi] && r_m_tnew > w_d_tuse[gi]));

            // Youngest match decides: ready -> forward, not ready -> hide older stages
            assign w_fwd_d[gi] =
                (w_d_src[gi] == '0)      ? FWD_RF :
                (r_e_dst == w_d_src[gi]) ? ((r_e_tnew == '0) ? FWD_E : FWD_RF) :
                (r_m_dst == w_d_src[gi]) ? ((r_m_tnew == '0) ? FWD_M : FWD_RF) :
                (r_w_dst == w_d_src[gi] && r_w_tnew == '0) ? FWD_W : FWD_RF;

            assign w_fwd_e[gi] =
                (w_e_src[gi] == '0)      ? FWD_RF :
                (r_m_dst == w_e_src[gi]) ? ((r_m_tnew == '0) ? FWD_M : FWD_RF) :
                (r_w_dst == w_e_src[gi] && r_w_tnew == '0) ? FWD_W : FWD_RF;
        end
    endgenerate

    assign fwd_rs_d = w_fwd_d[0];
    assign fwd_rt_d = w_fwd_d[1];
    assign fwd_rs_e = w_fwd_e[0];
    assign fwd_rt_e = w_fwd_e[1];

    // Store data needs the W bypass only if the producer was not yet ready
    // when the store sat in E; otherwise the value already rides in the pipe.
    assign fwd_rt_m = (r_m_rt != '0) && (r_w_dst == r_m_rt) &&
                      (r_w_tnew == '0) && !r_m_rt_fwd_done;

    // Never true in the default build: the decoder cannot emit these classes
    assign md_start = (r_e_cls == CLS_MULT) || (r_e_cls == CLS_DIV);

`ifdef MDU_HAZARD_EN
    localparam int MD_MAX = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int MD_CW  = $clog2(MD_MAX + 1);

    logic [MD_CW-1:0] r_md_cnt;
    logic             w_d_is_md;

    // Busy counter: load on launch, then count down to idle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_md_cnt <= '0;
        end else if (md_start) begin
            r_md_cnt <= (r_e_cls == CLS_DIV) ? MD_CW'(DIV_CYCLES) : MD_CW'(MULT_CYCLES);
        end else if (r_md_cnt != '0) begin
            r_md_cnt <= r_md_cnt - MD_CW'(1);
        end
    end

    assign md_busy    = (r_md_cnt != '0);
    assign w_d_is_md  = (w_d_cls == CLS_MULT) || (w_d_cls == CLS_DIV) ||
                        (w_d_cls == CLS_MF)   || (w_d_cls == CLS_MT);
    assign w_md_stall = w_d_is_md && (md_start || md_busy);
`else
    assign md_busy    = 1'b0;
    assign w_md_stall = 1'b0;
`endif

    assign stall = w_src_stall[0] | w_src_stall[1] | w_md_stall;

    // Advance the shadow pipe; a stalled D turns into a bubble in E
    always_ff @(posedge clk) begin
        if (reset) begin
            r_e_rs          <= '0;
            r_e_rt          <= '0;
            r_e_dst         <= '0;
            r_e_tnew        <= '0;
            r_e_cls         <= CLS_NOP;
            r_m_rt          <= '0;
            r_m_dst         <= '0;
            r_m_tnew        <= '0;
            r_m_rt_fwd_done <= 1'b0;
            r_w_dst         <= '0;
            r_w_tnew        <= '0;
        end else begin
            if (stall) begin
                r_e_rs   <= '0;
                r_e_rt   <= '0;
                r_e_dst  <= '0;
                r_e_tnew <= '0;
                r_e_cls  <= CLS_NOP;
            end else begin
                r_e_rs   <= w_d_rs;
                r_e_rt   <= w_d_rt;
                r_e_dst  <= w_d_dst;
                r_e_tnew <= w_d_tnew;
                r_e_cls  <= w_d_cls;
            end
            r_m_rt          <= r_e_rt;
            r_m_dst         <= r_e_dst;
            r_m_tnew        <= f_tnew_dec(r_e_tnew);
            r_m_rt_fwd_done <= (w_fwd_e[1] == FWD_M);
            r_w_dst         <= r_m_dst;
            r_w_tnew        <= f_tnew_dec(r_m_tnew);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard. The MULT/DIV sequence is exercised
// only when MDU_HAZARD_EN is defined; otherwise mult/mflo must act as nop.
module tb_hazard_scoreboard;

    logic        clk;
    logic        reset;
    logic [31:0] instr_d;
    logic        stall;
    logic [1:0]  fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
    logic        fwd_rt_m, md_start, md_busy;

    int total = 0;
    int bad   = 0;

    hazard_scoreboard dut (
        .clk      (clk),
        .reset    (reset),
        .instr_d  (instr_d),
        .stall    (stall),
        .fwd_rs_d (fwd_rs_d),
        .fwd_rt_d (fwd_rt_d),
        .fwd_rs_e (fwd_rs_e),
        .fwd_rt_e (fwd_rt_e),
        .fwd_rt_m (fwd_rt_m),
        .md_start (md_start),
        .md_busy  (md_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
    endfunction

    function automatic logic [31:0] itype(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    // Advance one clock, then present the next D instruction and reset level
    task automatic cyc(input logic [31:0] ins, input logic rst);
        @(posedge clk);
        #1;
        instr_d = ins;
        reset   = rst;
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
        $display("check %-14s got=%0d expected=%0d", tag, got, exp);
    endtask

    logic [31:0] i_nop, i_lw1, i_addu211, i_ori1, i_beq1, i_jal, i_jr31;
    logic [31:0] i_ori0, i_addu200, i_ori3, i_sw3, i_lw5, i_sw5, i_mult, i_mflo;

    initial begin
        i_nop     = 32'h0;
        i_lw1     = itype('h23, 0, 1, 0);
        i_addu211 = rtype(1, 1, 2, 'h21);
        i_ori1    = itype('h0d, 0, 1, 5);
        i_beq1    = itype('h04, 1, 0, 4);
        i_jal     = {6'h03, 26'h40};
        i_jr31    = rtype(31, 0, 0, 'h08);
        i_ori0    = itype('h0d, 0, 0, 7);
        i_addu200 = rtype(0, 0, 2, 'h21);
        i_ori3    = itype('h0d, 0, 3, 1);
        i_sw3     = itype('h2b, 0, 3, 0);
        i_lw5     = itype('h23, 0, 5, 0);
        i_sw5     = itype('h2b, 0, 5, 4);
        i_mult    = rtype(1, 2, 0, 'h18);
        i_mflo    = rtype(0, 0, 4, 'h12);

        reset   = 1'b1;
        instr_d = 32'h0;
        cyc(i_nop, 1'b1);
        cyc(i_nop, 1'b1);
        chk("rst_stall",    32'(stall),    0);
        chk("rst_fwd_rs_d", 32'(fwd_rs_d), 0);
        chk("rst_fwd_rt_d", 32'(fwd_rt_d), 0);
        chk("rst_fwd_rs_e", 32'(fwd_rs_e), 0);
        chk("rst_fwd_rt_e", 32'(fwd_rt_e), 0);
        chk("rst_fwd_rt_m", 32'(fwd_rt_m), 0);
        chk("rst_md_start", 32'(md_start), 0);
        chk("rst_md_busy",  32'(md_busy),  0);

        // lw $1 ; addu $2,$1,$1 : one-cycle load-use stall, then W bypass in E
        cyc(i_lw1, 1'b0);
        chk("t1_lw_nostall", 32'(stall), 0);
        cyc(i_addu211, 1'b0);
        chk("t1_stall",      32'(stall), 1);
        cyc(i_addu211, 1'b0);
        chk("t1_release",    32'(stall), 0);
        cyc(i_nop, 1'b0);
        chk("t1_fwd_rs_e",   32'(fwd_rs_e), 1);
        chk("t1_fwd_rt_e",   32'(fwd_rt_e), 1);

        // ori $1 ; beq $1,$0 : one-cycle stall, then M bypass to D
        cyc(i_ori1, 1'b0);
        chk("t2_ori_nostall", 32'(stall), 0);
        cyc(i_beq1, 1'b0);
        chk("t2_stall",       32'(stall), 1);
        cyc(i_beq1, 1'b0);
        chk("t2_release",     32'(stall), 0);
        chk("t2_fwd_rs_d",    32'(fwd_rs_d), 2);
        chk("t2_fwd_rt_d",    32'(fwd_rt_d), 0);

        // jal ; jr $31 : link value bypassed from E without stalling
        cyc(i_jal, 1'b0);
        cyc(i_jr31, 1'b0);
        chk("t3_stall",    32'(stall), 0);
        chk("t3_fwd_rs_d", 32'(fwd_rs_d), 3);

        // writes to $0 never create hazards
        cyc(i_ori0, 1'b0);
        cyc(i_addu200, 1'b0);
        chk("t4_stall",    32'(stall),    0);
        chk("t4_fwd_rs_d", 32'(fwd_rs_d), 0);
        chk("t4_fwd_rt_d", 32'(fwd_rt_d), 0);
        chk("t4_fwd_rs_e", 32'(fwd_rs_e), 0);
        chk("t4_fwd_rt_e", 32'(fwd_rt_e), 0);
        chk("t4_fwd_rt_m", 32'(fwd_rt_m), 0);

        // ori $3 ; sw $3 : store data tolerates tnew=1, M bypass in E, none in M
        cyc(i_ori3, 1'b0);
        cyc(i_sw3, 1'b0);
        chk("t5_stall",      32'(stall),    0);
        chk("t5_fwd_rt_d",   32'(fwd_rt_d), 0);
        cyc(i_nop, 1'b0);
        chk("t5_fwd_rt_e",   32'(fwd_rt_e), 2);
        chk("t5_fwd_rs_e",   32'(fwd_rs_e), 0);
        cyc(i_nop, 1'b0);
        chk("t5_fwd_rt_m",   32'(fwd_rt_m), 0);

        // lw $5 ; sw $5 : tnew==tuse does not stall; data arrives via W in M
        cyc(i_lw5, 1'b0);
        cyc(i_sw5, 1'b0);
        chk("t5b_stall",     32'(stall),    0);
        cyc(i_nop, 1'b0);
        chk("t5b_fwd_rt_e",  32'(fwd_rt_e), 0);
        cyc(i_nop, 1'b0);
        chk("t5b_fwd_rt_m",  32'(fwd_rt_m), 1);

        // reset while a stall is pending clears the shadow pipe
        cyc(i_ori1, 1'b0);
        cyc(i_beq1, 1'b1);
        chk("rst2_pre_stall", 32'(stall), 1);
        cyc(i_beq1, 1'b0);
        chk("rst2_stall",     32'(stall),    0);
        chk("rst2_fwd_rs_d",  32'(fwd_rs_d), 0);
        cyc(i_nop, 1'b0);
        cyc(i_nop, 1'b0);
        cyc(i_nop, 1'b0);

`ifdef MDU_HAZARD_EN
        // mult ; mflo : stall for MULT_CYCLES+1 cycles
        cyc(i_mult, 1'b0);
        chk("t6_mult_nostall", 32'(stall), 0);
        cyc(i_mflo, 1'b0);
        chk("t6_md_start",     32'(md_start), 1);
        chk("t6_stall0",       32'(stall),    1);
        for (int i = 0; i < 5; i++) begin
            cyc(i_mflo, 1'b0);
            chk("t6_busy_stall", 32'(stall),   1);
            chk("t6_busy",       32'(md_busy), 1);
        end
        cyc(i_mflo, 1'b0);
        chk("t6_release",  32'(stall),   0);
        chk("t6_idle",     32'(md_busy), 0);
        cyc(i_nop, 1'b0);

        // reset during busy cycle 2 aborts the MDU hazard
        cyc(i_mult, 1'b0);
        cyc(i_mflo, 1'b0);
        chk("t6r_md_start", 32'(md_start), 1);
        cyc(i_mflo, 1'b0);
        chk("t6r_busy1",    32'(md_busy),  1);
        cyc(i_mflo, 1'b1);
        chk("t6r_busy2",    32'(md_busy),  1);
        cyc(i_mflo, 1'b0);
        chk("t6r_busy_clr", 32'(md_busy),  0);
        chk("t6r_stall",    32'(stall),    0);
        chk("t6r_start",    32'(md_start), 0);
`else
        // without the MDU feature mult/mflo decode as nop
        cyc(i_mult, 1'b0);
        chk("t6_mult_nostall", 32'(stall), 0);
        cyc(i_mflo, 1'b0);
        chk("t6_md_start",     32'(md_start), 0);
        chk("t6_stall",        32'(stall),    0);
        chk("t6_md_busy",      32'(md_busy),  0);
`endif

        cyc(i_nop, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
